// File: rtl/serdes_link_ctrl.sv
// Link-layer controller: byte serializer with periodic SYNC insertion and a SYNC-hunting deserializer.
// Optional error counter port err_cnt is built when SERDES_ERRCNT_EN is defined.
module serdes_link_ctrl #(
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         SYNC_INTERVAL = 16,
    parameter int         MISS_MAX      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_en,
    input  logic       par_en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ser_out,
    input  logic       ser_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       locked
`ifdef SERDES_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int SLOT_W = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;
    localparam logic [SLOT_W-1:0] SLOT_ZERO = {SLOT_W{1'b0}};
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SYNC_INTERVAL - 1);
    localparam logic [SLOT_W-1:0] LOCK_SLOT = (SYNC_INTERVAL > 1) ? SLOT_W'(1) : SLOT_ZERO;
    localparam logic [3:0]        MISS_LIMIT = 4'(MISS_MAX);

    typedef enum logic [0:0] {
        RX_HUNT   = 1'b0,
        RX_LOCKED = 1'b1
    } rx_state_t;

    function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
        if (s == SLOT_LAST) begin
            return SLOT_ZERO;
        end else begin
            return s + SLOT_W'(1);
        end
    endfunction

    logic [7:0]        tx_shift_r;
    logic [2:0]        tx_bit_r;
    logic [SLOT_W-1:0] tx_slot_r;
    logic [7:0]        tx_load_s;

    // Byte chosen at a load cycle: slot 0 and idle slots carry SYNC.
    always_comb begin
        tx_load_s = SYNC_BYTE;
        if (tx_slot_r == SLOT_ZERO) begin
            tx_load_s = SYNC_BYTE;
        end else if (tx_valid) begin
            tx_load_s = tx_data;
        end else begin
            tx_load_s = SYNC_BYTE;
        end
    end

    // TX shifter, bit counter and slot counter; disabling aborts the byte in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift_r <= 8'h00;
            tx_bit_r   <= 3'd7;
            tx_slot_r  <= SLOT_ZERO;
        end else if (!ser_en) begin
            tx_shift_r <= 8'h00;
            tx_bit_r   <= 3'd7;
            tx_slot_r  <= SLOT_ZERO;
        end else if (tx_bit_r == 3'd7) begin
            tx_shift_r <= tx_load_s;
            tx_bit_r   <= 3'd0;
            tx_slot_r  <= slot_inc(tx_slot_r);
        end else begin
            tx_shift_r <= {tx_shift_r[6:0], 1'b0};
            tx_bit_r   <= tx_bit_r + 3'd1;
        end
    end

    assign ser_out  = tx_shift_r[7];
    assign tx_ready = !rst && ser_en && (tx_bit_r == 3'd7) && (tx_slot_r != SLOT_ZERO);

    rx_state_t         state_r, state_s;
    logic [7:0]        rx_shift_r, rx_shift_s;
    logic [7:0]        nxt_s;
    logic [2:0]        rx_bit_r, rx_bit_s;
    logic [SLOT_W-1:0] rx_slot_r, rx_slot_s;
    logic [3:0]        miss_r, miss_s;
    logic [7:0]        rx_data_r, rx_data_s;
    logic              rx_valid_r, rx_valid_s;

    assign nxt_s = {rx_shift_r[6:0], ser_in};

    // RX next-state: hunt for SYNC, then track byte/slot boundaries and sync misses.
    always_comb begin
        state_s    = state_r;
        rx_shift_s = rx_shift_r;
        rx_bit_s   = rx_bit_r;
        rx_slot_s  = rx_slot_r;
        miss_s     = miss_r;
        rx_data_s  = rx_data_r;
        rx_valid_s = 1'b0;
        if (!par_en) begin
            state_s   = RX_HUNT;
            rx_bit_s  = 3'd0;
            rx_slot_s = SLOT_ZERO;
            miss_s    = 4'd0;
        end else begin
            rx_shift_s = nxt_s;
            case (state_r)
                RX_HUNT: begin
                    if (nxt_s == SYNC_BYTE) begin
                        state_s   = RX_LOCKED;
                        rx_bit_s  = 3'd0;
                        rx_slot_s = LOCK_SLOT;
                        miss_s    = 4'd0;
                    end else begin
                        state_s = RX_HUNT;
                    end
                end
                RX_LOCKED: begin
                    if (rx_bit_r != 3'd7) begin
                        rx_bit_s = rx_bit_r + 3'd1;
                    end else begin
                        rx_bit_s  = 3'd0;
                        rx_slot_s = slot_inc(rx_slot_r);
                        if (rx_slot_r == SLOT_ZERO) begin
                            if (nxt_s == SYNC_BYTE) begin
                                miss_s = 4'd0;
                            end else if ((miss_r + 4'd1) == MISS_LIMIT) begin
                                state_s   = RX_HUNT;
                                miss_s    = 4'd0;
                                rx_slot_s = SLOT_ZERO;
                            end else begin
                                miss_s = miss_r + 4'd1;
                            end
                        end else if (nxt_s != SYNC_BYTE) begin
                            rx_data_s  = nxt_s;
                            rx_valid_s = 1'b1;
                        end else begin
                            rx_valid_s = 1'b0;
                        end
                    end
                end
                default: begin
                    state_s = RX_HUNT;
                end
            endcase
        end
    end

    // RX state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RX_HUNT;
            rx_shift_r <= 8'h00;
            rx_bit_r   <= 3'd0;
            rx_slot_r  <= SLOT_ZERO;
            miss_r     <= 4'd0;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            rx_shift_r <= rx_shift_s;
            rx_bit_r   <= rx_bit_s;
            rx_slot_r  <= rx_slot_s;
            miss_r     <= miss_s;
            rx_data_r  <= rx_data_s;
            rx_valid_r <= rx_valid_s;
        end
    end

    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign locked   = (state_r == RX_LOCKED);

`ifdef SERDES_ERRCNT_EN
    logic       bad_sync_s;
    logic       drop_lock_s;
    logic [8:0] err_sum_s;
    logic [7:0] err_cnt_r;

    assign bad_sync_s  = par_en && (state_r == RX_LOCKED) && (rx_bit_r == 3'd7) &&
                         (rx_slot_r == SLOT_ZERO) && (nxt_s != SYNC_BYTE);
    assign drop_lock_s = (state_r == RX_LOCKED) && (state_s == RX_HUNT);
    assign err_sum_s   = {1'b0, err_cnt_r} + {8'd0, bad_sync_s} + {8'd0, drop_lock_s};

    // Saturating link error counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 8'h00;
        end else if (err_sum_s[8]) begin
            err_cnt_r <= 8'hFF;
        end else begin
            err_cnt_r <= err_sum_s[7:0];
        end
    end

    assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_serdes_link_ctrl.sv
// Self-checking bench for serdes_link_ctrl: slot/bit-count reference model, loopback scoreboard,
// directed link scenarios and a randomized phase.
module tb_serdes_link_ctrl;

    localparam int         SI   = 16;
    localparam int         MISS = 2;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst, ser_en, par_en, tx_valid, tx_ready, ser_out, rx_valid, locked;
    logic [7:0] tx_data, rx_data;
    logic       loop_en, inv, rnd_bit, sb_en;
    wire        ser_in = loop_en ? (ser_out ^ inv) : rnd_bit;
`ifdef SERDES_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    serdes_link_ctrl #(.SYNC_BYTE(SYNC), .SYNC_INTERVAL(SI), .MISS_MAX(MISS)) dut (
        .clk(clk), .rst(rst), .ser_en(ser_en), .par_en(par_en),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ser_out(ser_out), .ser_in(ser_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .locked(locked)
`ifdef SERDES_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: TX position is the count of enabled edges since enable; RX byte
    // boundaries are every 8th edge after lock, slot = (bytes since lock) mod SI.
    bit         m_valid = 0;
    int         m_e, m_b, m_miss, m_err;
    logic [7:0] m_cur, m_win, m_rxd;
    bit         m_locked, m_rxv, m_acc;
    logic [7:0] sb[$];

    always @(posedge clk) begin : model
        int slot;
        m_acc = 0;
        if (rst) begin
            m_valid = 1; m_e = 0; m_cur = 8'h00; m_locked = 0; m_win = 8'h00;
            m_b = 0; m_miss = 0; m_rxv = 0; m_rxd = 8'h00; m_err = 0;
        end else begin
            if (!ser_en) begin
                m_e = 0; m_cur = 8'h00;
            end else begin
                if (m_e % 8 == 0) begin
                    slot = (m_e / 8) % SI;
                    if (slot != 0 && tx_valid) begin
                        m_cur = tx_data; m_acc = 1;
                        if (sb_en) sb.push_back(tx_data);
                    end else begin
                        m_cur = SYNC;
                    end
                end
                m_e++;
            end
            m_rxv = 0;
            if (!par_en) begin
                if (m_locked) m_err++;
                m_locked = 0;
            end else begin
                m_win = {m_win[6:0], ser_in};
                if (!m_locked) begin
                    if (m_win == SYNC) begin m_locked = 1; m_b = 0; m_miss = 0; end
                end else begin
                    m_b++;
                    if (m_b % 8 == 0) begin
                        if ((m_b / 8) % SI == 0) begin
                            if (m_win == SYNC) m_miss = 0;
                            else begin
                                m_err++; m_miss++;
                                if (m_miss == MISS) begin m_locked = 0; m_miss = 0; m_err++; end
                            end
                        end else if (m_win != SYNC) begin
                            m_rxv = 1; m_rxd = m_win;
                        end
                    end
                end
            end
            if (m_err > 255) m_err = 255;
        end
    end

    // Cycle compare against the model plus in-order scoreboard of looped-back payload.
    int rx_cnt = 0;
    always @(negedge clk) begin
        logic exp_ser, exp_rdy;
        if (m_valid) begin
            exp_ser = (m_e == 0) ? 1'b0 : m_cur[7 - ((m_e - 1) % 8)];
            exp_rdy = !rst && ser_en && (m_e % 8 == 0) && (((m_e / 8) % SI) != 0);
            chk("ser_out", ser_out, exp_ser);
            chk("tx_ready", tx_ready, exp_rdy);
            chk("locked", locked, m_locked);
            chk("rx_valid", rx_valid, m_rxv);
            chk("rx_data", rx_data, m_rxd);
`ifdef SERDES_ERRCNT_EN
            chk("err_cnt", err_cnt, m_err);
`endif
            if (sb_en && m_rxv) begin
                rx_cnt++;
                if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
                else chk("sb_order", rx_data, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        bit         ok;
        int         acc_cnt;
        rst = 1'b1; ser_en = 1'b1; par_en = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
        loop_en = 1'b1; inv = 1'b0; rnd_bit = 1'b0; sb_en = 1'b0;

        // 1: first load after reset is SYNC, lock after 8 bits
        do_reset();
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1_bit", ser_out, pat[7-i]);
            chk("t1_unlocked", locked, 1'b0);
        end
        tick();
        chk("t1_locked", locked, 1'b1);

        // 2: single payload byte, loopback latency
        tx_data = 8'h3C; tx_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (m_acc) begin ok = 1; break; end end
        chk("t2_accept", ok, 1'b1);
        tx_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 7 || k == 9) chk("t2_no_pulse", rx_valid, 1'b0);
            if (k == 8) begin chk("t2_pulse", rx_valid, 1'b1); chk("t2_data", rx_data, 8'h3C); end
        end

        // 3: streaming 256 cycles, two sync slots steal loads
        do_reset();
        sb_en = 1'b1; tx_valid = 1'b1; tx_data = 8'h00; acc_cnt = 0; rx_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (m_acc) begin acc_cnt++; tx_data = tx_data + 8'd1; end
        end
        tx_valid = 1'b0;
        for (int i = 0; i < 24; i++) tick();
        chk("t3_accepts", acc_cnt, 30);
        chk("t3_received", rx_cnt, 30);
        chk("t3_sb_left", sb.size(), 0);
        sb_en = 1'b0;

        // 4: two corrupted sync slots drop lock, then relock
        do_reset();
        ok = 0;
        for (int i = 0; i < 400; i++) begin tick(); if (m_e == 8 * SI + 1) begin ok = 1; break; end end
        chk("t4_wait1", ok, 1'b1);
        inv = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        inv = 1'b0;
        chk("t4_first_miss_locked", locked, 1'b1);
        ok = 0;
        for (int i = 0; i < 400; i++) begin tick(); if (m_e == 16 * SI + 1) begin ok = 1; break; end end
        chk("t4_wait2", ok, 1'b1);
        inv = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        inv = 1'b0;
        chk("t4_second_miss_unlocked", locked, 1'b0);
        ok = 0;
        for (int i = 0; i < 24; i++) begin tick(); if (locked) begin ok = 1; break; end end
        chk("t4_relock", ok, 1'b1);
`ifdef SERDES_ERRCNT_EN
        chk("t4_err_cnt", err_cnt, 8'd3);
`endif

        // 5: abort at bit 3 of a payload byte, re-enable restarts with SYNC
        do_reset();
        tx_data = 8'h77; tx_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (m_acc) begin ok = 1; break; end end
        chk("t5_accept", ok, 1'b1);
        tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        ser_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_ser_idle", ser_out, 1'b0);
            chk("t5_ready_idle", tx_ready, 1'b0);
        end
        ser_en = 1'b1; tx_valid = 1'b1;
        #1 chk("t5_ready_slot0", tx_ready, 1'b0);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5_sync_bit", ser_out, pat[7-i]);
        end
        tx_valid = 1'b0;

        // 6: reset in the middle of a received byte
        do_reset();
        tx_data = 8'h5A; tx_valid = 1'b1; acc_cnt = 0;
        for (int i = 0; i < 60 && acc_cnt < 2; i++) begin tick(); if (m_acc) acc_cnt++; end
        chk("t6_accepts", acc_cnt, 2);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_pre_data", rx_data, 8'h5A);
        rst = 1'b1;
        tick();
        chk("t6_ser_out", ser_out, 1'b0);
        chk("t6_locked", locked, 1'b0);
        chk("t6_rx_valid", rx_valid, 1'b0);
        chk("t6_rx_data", rx_data, 8'h00);
        chk("t6_tx_ready", tx_ready, 1'b0);
`ifdef SERDES_ERRCNT_EN
        chk("t6_err_cnt", err_cnt, 8'd0);
`endif
        rst = 1'b0; tx_valid = 1'b0;

        // Randomized phase: traffic, enable drops, bit flips, open-loop noise, rare resets
        for (int seg = 0; seg < 6; seg++) begin
            loop_en = (seg != 3);
            for (int i = 0; i < 500; i++) begin
                tick();
                tx_valid = ($urandom_range(0, 3) != 0);
                tx_data  = 8'($urandom_range(0, 255));
                rnd_bit  = 1'($urandom_range(0, 1));
                inv      = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 199) == 0) ser_en = ~ser_en;
                if ($urandom_range(0, 199) == 0) par_en = ~par_en;
                rst = ($urandom_range(0, 999) == 0);
            end
            ser_en = 1'b1; par_en = 1'b1; rst = 1'b0; inv = 1'b0;
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serdes_link_ctrl.md
Name: serdes_link_ctrl

Overview:
- Link-layer controller for the 8-bit SERDES datapath.
- TX side: accepts parallel bytes over a valid/ready handshake and serializes them MSB-first. Forces a SYNC byte every SYNC_INTERVAL byte slots and fills idle slots with SYNC.
- RX side: hunts for SYNC in the serial stream, locks to byte boundaries and emits payload bytes. Drops lock after MISS_MAX consecutive bad sync slots.
- Sits between the top-level pin wrapper and the serial pins. Replaces the free-running enables with a sequenced link.

Parameters:
SYNC_BYTE, 8'hA5, framing/idle pattern; payload bytes equal to this are discarded at RX.
SYNC_INTERVAL, 16, byte slots per frame; slot 0 always carries SYNC (legal range 2..256).
MISS_MAX, 2, consecutive bad sync slots that force RX back to HUNT (legal range 1..15).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
ser_en  input  1  TX enable; low aborts and holds TX idle
par_en  input  1  RX enable; low forces HUNT and holds RX idle
tx_data  input  8  parallel byte to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  byte accepted when tx_valid && tx_ready at a rising edge
ser_out  output  1  serial TX bit, registered
ser_in  input  1  serial RX bit
rx_data  output  8  received payload byte, registered
rx_valid  output  1  one-cycle pulse, rx_data valid
locked  output  1  RX in LOCKED state

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - TX: tx_shift=0, ser_out=0, tx_bit=7, tx_slot=0.
  - RX: rx_shift=0, rx_data=0, rx_valid=0, state=HUNT, locked=0, rx_bit=0, rx_slot=0, miss_cnt=0.
  - tx_ready is combinational and therefore 0 during reset.
- TX:
  - ser_out = tx_shift[7]. Each enabled cycle with tx_bit!=7, tx_shift shifts left 1 and tx_bit increments.
  - tx_bit==7 with ser_en=1 is a load cycle. tx_bit then wraps to 0 and tx_slot increments modulo SYNC_INTERVAL.
  - Load rule: if tx_slot==0, load SYNC_BYTE. Else if tx_valid, load tx_data. Else load SYNC_BYTE (idle fill).
  - tx_ready = ser_en && tx_bit==7 && tx_slot!=0. tx_valid must not depend on tx_ready.
  - First load after reset or after ser_en rises always sends SYNC.
  - ser_en=0: next edge sets tx_shift=0, tx_bit=7 and tx_slot=0, aborting any byte in flight. A partially sent byte is lost. Byte rate is exactly 1 per 8 cycles.
- RX:
  - Sampling: when par_en=1, every cycle computes nxt={rx_shift[6:0],ser_in} and registers it into rx_shift.
  - HUNT: if nxt==SYNC_BYTE, go to LOCKED with rx_bit=0, rx_slot=1 (slot 1 if SYNC_INTERVAL>1, else 0) and miss_cnt=0.
  - LOCKED: rx_bit increments each cycle. When rx_bit==7, the byte nxt is complete; rx_bit wraps to 0 and rx_slot increments modulo SYNC_INTERVAL.
  - Sync slot (rx_slot==0):
    - nxt==SYNC_BYTE: miss_cnt=0.
    - Otherwise: miss_cnt increments; if the new value equals MISS_MAX, go to HUNT and set miss_cnt=0.
    - No rx_valid is generated for the sync slot.
  - Payload slot: if nxt!=SYNC_BYTE, rx_data<=nxt and rx_valid=1 for one cycle. Otherwise the byte is treated as idle and dropped.
  - locked=1 iff state==LOCKED.
  - par_en=0: next edge forces HUNT, rx_bit=0, rx_slot=0, miss_cnt=0 and rx_valid=0. rx_shift holds.
- Loopback latency (ser_in tied to ser_out): handshake at cycle T → bit7 on ser_out in T+1 → bit0 in T+8 → rx_valid and rx_data in T+9.
- Simultaneous events: rst has priority over everything. Within RX, par_en=0 has priority over a sync miss or a byte completion in the same cycle.

Optional Feature:
SERDES_ERRCNT_EN
- Defined: adds output err_cnt [7:0], reset 0.
  - Increments on every bad sync slot and every LOCKED→HUNT transition; both in one cycle add 2.
  - Saturates at 255 and is cleared only by rst.
- Undefined: the port and its logic are absent.

Test Plan:
1. Reset with ser_en=1, par_en=1, loopback (ser_in=ser_out), tx_valid=0 → first load at cycle 0 sends 8'hA5 with ser_out bits 1,0,1,0,0,1,0,1 in cycles 1..8; locked=1 in cycle 9; rx_valid never pulses.
2. While locked, present tx_data=8'h3C with tx_valid and handshake at cycle T → rx_data=8'h3C, rx_valid=1 for exactly one cycle at T+9.
3. tx_valid held high with an incrementing byte on each accept, for 256 cycles → tx_ready is low on every 16th load slot; exactly 30 bytes accepted; all 30 received in order.
4. Invert ser_in during two consecutive sync slots with MISS_MAX=2 → first bad slot keeps locked=1; locked=0 the cycle after the second bad slot completes; relock on the next clean SYNC.
5. Drop ser_en at bit 3 of a payload byte → ser_out=0 from the next cycle; tx_ready=0; on re-enable the first byte sent is SYNC_BYTE.
6. Assert rst mid-byte with rx_valid pending → the next cycle shows all reset values, including locked=0 and rx_valid=0. With SERDES_ERRCNT_EN, scenario 4 yields err_cnt=3.
